// File: rtl/nios_mult_pkg.sv
// Shared definitions for the pipelined multiplier: operation encoding and
// default operand/tag widths.
package nios_mult_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned TAG_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXSS = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXUU = 2'd3
  } mult_op_e;

endpackage

// File: rtl/nios_mult_pipe_stage.sv
// Generic valid/data pipeline register slice.
//   clk, reset_n     : clock, asynchronous active-low reset
//   in_valid/in_data : upstream payload, captured when adv is high
//   adv              : stage may advance (downstream can take our contents)
//   out_valid/out_data: registered stage contents, held while adv is low
module nios_mult_pipe_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          adv,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          valid_d, valid_q;
  logic [DW-1:0] data_d, data_q;

  // Data only loads on a real operation so bubbles never disturb held values.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/nios_mult_pipe.sv
// Two-stage pipelined multiplier with valid/ready handshake on both sides.
// S1 holds half-width partial products, S2 holds the summed, selected word.
// Optional feature macro NIOS_MULT_PIPE_MULX_EN adds the hi*hi product and the
// high-word ops (MULXSS/MULXSU/MULXUU); without it every op returns the low word.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready             : operation handshake
//   in_op, in_src1, in_src2, in_tag : operation, operands, sideband tag
//   out_valid/out_ready           : result handshake
//   out_result, out_tag           : product word and its tag
module nios_mult_pipe
  import nios_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned H  = WIDTH / 2;
`ifdef NIOS_MULT_PIPE_MULX_EN
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned S1_W = 2 + 5 * WIDTH + TAG_W;
`else
  localparam int unsigned S1_W = 3 * WIDTH + TAG_W;
`endif
  localparam int unsigned S2_W = WIDTH + TAG_W;

  logic            adv1_c, adv2_c;
  logic            v1, v2;
  logic [S1_W-1:0] s1_in, s1_out;
  logic [S2_W-1:0] s2_in, s2_out;

  // Handshake: a stage advances if it is empty or the one after it advances.
  assign adv2_c   = ~v2 | out_ready;
  assign adv1_c   = ~v1 | adv2_c;
  assign in_ready = adv1_c;

  // S1 input: H x H unsigned partial products.
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl;
  always_comb begin
    pp_ll = WIDTH'(in_src1[H-1:0])     * WIDTH'(in_src2[H-1:0]);
    pp_lh = WIDTH'(in_src1[H-1:0])     * WIDTH'(in_src2[WIDTH-1:H]);
    pp_hl = WIDTH'(in_src1[WIDTH-1:H]) * WIDTH'(in_src2[H-1:0]);
  end

`ifdef NIOS_MULT_PIPE_MULX_EN
  logic [WIDTH-1:0] pp_hh, corr;
  mult_op_e         op_in;

  // Operand sign bits are folded into one correction term subtracted from the
  // unsigned high word in S2.
  always_comb begin
    op_in = mult_op_e'(in_op);
    pp_hh = WIDTH'(in_src1[WIDTH-1:H]) * WIDTH'(in_src2[WIDTH-1:H]);
    corr  = '0;
    if ((op_in == OP_MULXSS || op_in == OP_MULXSU) && in_src1[WIDTH-1])
      corr = in_src2;
    if (op_in == OP_MULXSS && in_src2[WIDTH-1])
      corr = corr + in_src1;
    s1_in = {in_op, pp_hh, corr, pp_ll, pp_lh, pp_hl, in_tag};
  end
`else
  logic unused_op_c;
  assign unused_op_c = ^in_op;
  assign s1_in = {pp_ll, pp_lh, pp_hl, in_tag};
`endif

  nios_mult_pipe_stage #(.DW(S1_W)) u_s1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .adv      (adv1_c),
    .in_data  (s1_in),
    .out_valid(v1),
    .out_data (s1_out)
  );

  // S2 input: sum partial products and select the requested word.
  logic [WIDTH-1:0] s1_ll, s1_lh, s1_hl, res;
  logic [TAG_W-1:0] s1_tag;
`ifdef NIOS_MULT_PIPE_MULX_EN
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_hh, s1_corr, hi;
  logic [PW-1:0]    prod;
  always_comb begin
    {s1_op, s1_hh, s1_corr, s1_ll, s1_lh, s1_hl, s1_tag} = s1_out;
    prod = PW'(s1_ll) + (PW'(s1_lh) << H) + (PW'(s1_hl) << H) + (PW'(s1_hh) << WIDTH);
    hi   = prod[PW-1:WIDTH] - s1_corr;
    res  = (mult_op_e'(s1_op) == OP_MUL) ? prod[WIDTH-1:0] : hi;
  end
`else
  always_comb begin
    {s1_ll, s1_lh, s1_hl, s1_tag} = s1_out;
    res = s1_ll + ((s1_lh + s1_hl) << H);
  end
`endif
  assign s2_in = {res, s1_tag};

  nios_mult_pipe_stage #(.DW(S2_W)) u_s2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (v1),
    .adv      (adv2_c),
    .in_data  (s2_in),
    .out_valid(v2),
    .out_data (s2_out)
  );

  assign out_valid             = v2;
  assign {out_result, out_tag} = s2_out;

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Directed self-checking bench for nios_mult_pipe (WIDTH=32, TAG_W=5).
module tb_nios_mult_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios_mult_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag)
  );

  // Expected high-word results depend on whether the high-word ops are built.
`ifdef NIOS_MULT_PIPE_MULX_EN
  localparam logic [31:0] E_UU_FF  = 32'hFFFF_FFFE;
  localparam logic [31:0] E_SS_FF  = 32'h0000_0000;
  localparam logic [31:0] E_SU_FF  = 32'hFFFF_FFFF;
  localparam logic [31:0] E_UU_1K  = 32'h0000_0001;
  localparam logic [31:0] E_SS_N2  = 32'hFFFF_FFFF;
  localparam logic [31:0] E_SU_P3  = 32'h0000_0002;
`else
  localparam logic [31:0] E_UU_FF  = 32'h0000_0001;
  localparam logic [31:0] E_SS_FF  = 32'h0000_0001;
  localparam logic [31:0] E_SU_FF  = 32'h0000_0001;
  localparam logic [31:0] E_UU_1K  = 32'h0000_0000;
  localparam logic [31:0] E_SS_N2  = 32'hFFFF_FFFA;
  localparam logic [31:0] E_SU_P3  = 32'hFFFF_FFFA;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One isolated op with out_ready high: checks accept, 2-cycle latency, data, drain.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp_v);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tg; out_ready = 1'b1;
    #1 check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check({nm, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 check({nm, "_lat2_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_result"}, 64'(out_result), 64'(exp_v));
    check({nm, "_tag"}, 64'(out_tag), 64'(tg));
    @(negedge clk);
    #1 check({nm, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [31:0] se [8];
  logic [4:0]  st [8];

  initial begin
    int sent, rcv;
    sa = '{32'd3, 32'h0001_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'd7, 32'h8000_0000, 32'h0000_FFFF, 32'h100};
    sb = '{32'd5, 32'h0001_0000, 32'd2,         32'h10,        32'd9, 32'd3,         32'h0000_FFFF, 32'h100};
    se = '{32'd15, 32'h0, 32'hFFFF_FFFE, 32'h2345_6780, 32'd63, 32'h8000_0000, 32'hFFFE_0001, 32'h0001_0000};
    st = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};

    // Reset state.
    reset_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_src1 = '0; in_src2 = '0;
    in_tag = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single operations.
    run_op("mul_ff",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0001);
    run_op("mulxuu_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  E_UU_FF);
    run_op("mulxss_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, E_SS_FF);
    run_op("mulxsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, E_SU_FF);
    run_op("mulxuu_1k", 2'd3, 32'h0001_0000, 32'h0001_0000, 5'd12, E_UU_1K);
    run_op("mul_1k",    2'd0, 32'h0001_0000, 32'h0001_0000, 5'd13, 32'h0000_0000);
    run_op("mulxss_n2", 2'd1, 32'hFFFF_FFFE, 32'd3,         5'd14, E_SS_N2);
    run_op("mulxsu_p3", 2'd2, 32'd3,         32'hFFFF_FFFE, 5'd31, E_SU_P3);

    // Back-to-back stream with out_ready low in cycles 2..4.
    sent = 0; rcv = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      in_op     = 2'd0;
      in_src1   = sa[sent % 8];
      in_src2   = sb[sent % 8];
      in_tag    = st[sent % 8];
      out_ready = !(c >= 2 && c <= 4);
      #1;
      check($sformatf("stream_in_ready_c%0d", c), 64'(in_ready), 64'((c < 2) || (c > 4)));
      check($sformatf("stream_out_valid_c%0d", c), 64'(out_valid), 64'((c >= 2) && (c <= 12)));
      if (out_valid && rcv < 8) begin
        check($sformatf("stream_result_c%0d", c), 64'(out_result), 64'(se[rcv]));
        check($sformatf("stream_tag_c%0d", c), 64'(out_tag), 64'(st[rcv]));
        if (out_ready) rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check("stream_sent", 64'(sent), 64'd8);
    check("stream_rcv", 64'(rcv), 64'd8);

    // Reset with two ops in flight.
    @(negedge clk);
    in_valid = 1'b1; in_src1 = 32'd6; in_src2 = 32'd7; in_tag = 5'd20; out_ready = 1'b1;
    @(negedge clk);
    in_src1 = 32'd8; in_src2 = 32'd9; in_tag = 5'd21;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("inflight_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_result", 64'(out_result), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    in_op = 'x; in_src1 = 'x; in_src2 = 'x; in_tag = 'x;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check($sformatf("after_rst_quiet_c%0d", c), 64'(out_valid), 64'd0);
    end
    run_op("after_rst_mul", 2'd0, 32'h0000_1234, 32'h0000_0100, 5'd17, 32'h0012_3400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
